// File: rtl/s2mm_frame_scheduler_pkg.sv
// Shared types and constants for the S2MM frame scheduler.
package s2mm_sched_pkg;

  // Buffer index width, fixed to cover a ring of up to four buffers.
  localparam int C_IDX_BITS = 2;

  // Capture control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Ceiling log2, never less than 1, so it can size a counter that holds 'value-1'.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/s2mm_frame_scheduler_if.sv
// Control link between the scheduler and the S2MM frame writer.
interface s2mm_frame_scheduler_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32
);
  logic                          soft_resetn;
  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr;
  logic                          frame_pulse;
  logic                          resetting;

  // Scheduler side: drives the writer's reset and frame address.
  modport master (output soft_resetn, output base_addr, input frame_pulse, input resetting);
  // Writer side.
  modport slave  (input soft_resetn, input base_addr, output frame_pulse, output resetting);
endinterface

// File: rtl/s2mm_next_buf_sel.sv
// Picks the next buffer to write: first of wr_idx+1, wr_idx+2, ... (mod C_BUF_NUM)
// that is not held by the reader. The current buffer is never a candidate.
module s2mm_next_buf_sel
  import s2mm_sched_pkg::*;
#(
  parameter int C_BUF_NUM = 3
) (
  input  logic [C_IDX_BITS-1:0] wr_idx,
  input  logic                  rd_lock,
  input  logic [C_IDX_BITS-1:0] rd_idx,
  output logic                  found,
  output logic [C_IDX_BITS-1:0] next_idx
);

  localparam logic [C_IDX_BITS:0] C_NUM = (C_IDX_BITS+1)'(C_BUF_NUM);

  logic                w_lock_valid;
  logic [C_IDX_BITS:0] w_sum;

  // Walk the ring in order and keep the first buffer the reader does not hold.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    found        = 1'b0;
    next_idx     = wr_idx;
    w_sum        = '0;
    // An out-of-range reader index cannot name a real buffer, so it locks nothing.
    w_lock_valid = rd_lock && ({1'b0, rd_idx} < C_NUM);
    for (int k = 1; k < C_BUF_NUM; k++) begin
      w_sum = {1'b0, wr_idx} + (C_IDX_BITS+1)'(k);
      if (w_sum >= C_NUM) w_sum = w_sum - C_NUM;
      if (!found && !(w_lock_valid && (w_sum[C_IDX_BITS-1:0] == rd_idx))) begin
        found    = 1'b1;
        next_idx = w_sum[C_IDX_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/s2mm_frame_scheduler.sv
// Runs the S2MM writer over a ring of frame buffers: start/stop of capture,
// next-buffer selection on every completed frame, and publication of the
// newest complete buffer to the reader.
module s2mm_frame_scheduler
  import s2mm_sched_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_BUF_NUM          = 3,
  parameter int C_CNT_BITS         = 16,
  parameter int C_STOP_MIN         = 2
) (
  input  logic                                    M_AXI_ACLK,
  input  logic                                    M_AXI_ARESETN,
  input  logic                                    enable,
  input  logic [C_BUF_NUM*C_M_AXI_ADDR_WIDTH-1:0] buf_addr,
  input  logic                                    rd_lock,
  input  logic [C_IDX_BITS-1:0]                   rd_idx,
  s2mm_frame_scheduler_if.master                  wr_if,
  output logic [C_IDX_BITS-1:0]                   wr_idx,
  output logic [C_IDX_BITS-1:0]                   latest_idx,
  output logic                                    latest_valid,
  output logic [C_CNT_BITS-1:0]                   frame_cnt,
  output logic [C_CNT_BITS-1:0]                   drop_cnt,
  output logic                                    busy
);

  localparam int C_STOP_BITS = clogb2(C_STOP_MIN + 1);

  state_t                        r_state, w_next_state;
  logic                          w_sel_fire;
  logic                          w_found;
  logic [C_IDX_BITS-1:0]         w_next_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_cur_addr, w_next_addr;
  logic [C_STOP_BITS-1:0]        r_stop_cnt;
  logic                          r_soft_resetn;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_base_addr;
  logic [C_IDX_BITS-1:0]         r_wr_idx, r_latest_idx;
  logic                          r_latest_valid, r_busy;
  logic [C_CNT_BITS-1:0]         r_frame_cnt, r_drop_cnt;

  s2mm_next_buf_sel #(.C_BUF_NUM(C_BUF_NUM)) u_sel (
    .wr_idx   (r_wr_idx),
    .rd_lock  (rd_lock),
    .rd_idx   (rd_idx),
    .found    (w_found),
    .next_idx (w_next_idx)
  );

  // Look up the base addresses of the current and the candidate buffer.
  always_comb begin
    w_cur_addr  = '0;
    w_next_addr = '0;
    for (int i = 0; i < C_BUF_NUM; i++) begin
      if (r_wr_idx == C_IDX_BITS'(i))   w_cur_addr  = buf_addr[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
      if (w_next_idx == C_IDX_BITS'(i)) w_next_addr = buf_addr[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
    end
  end

  // Next-state logic; a completed frame is selected on in RUN and in STOP alike.
  always_comb begin
    // NOTE: combinational blocks use blocking '='; only clocked state uses '<='.
    w_next_state = r_state;
    w_sel_fire   = 1'b0;
    case (r_state)
      ST_IDLE: if (enable && !wr_if.resetting) w_next_state = ST_RUN;
      ST_RUN: begin
        w_sel_fire = wr_if.frame_pulse;
        if (!enable) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        w_sel_fire = wr_if.frame_pulse;
        if ((r_stop_cnt == '0) && !wr_if.resetting) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_next_state;
  end

  // Registered outputs, stop timer and buffer selection.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_soft_resetn  <= 1'b0;
      r_base_addr    <= '0;
      r_wr_idx       <= '0;
      r_latest_idx   <= '0;
      r_latest_valid <= 1'b0;
      r_frame_cnt    <= '0;
      r_drop_cnt     <= '0;
      r_busy         <= 1'b0;
      r_stop_cnt     <= '0;
    end else begin
      // Writer runs only in RUN; dropping it on the RUN->STOP edge stops new bursts cleanly.
      r_soft_resetn <= (w_next_state == ST_RUN);
      r_busy        <= (w_next_state != ST_IDLE);

      if ((r_state == ST_RUN) && (w_next_state == ST_STOP))
        r_stop_cnt <= C_STOP_BITS'(C_STOP_MIN);
      else if ((r_state == ST_STOP) && (r_stop_cnt != '0))
        r_stop_cnt <= r_stop_cnt - C_STOP_BITS'(1);

      // While idle, keep following buf_addr so a restart uses the current address.
      if (r_state == ST_IDLE) r_base_addr <= w_cur_addr;

      // Selection lands one edge after frame_pulse; the writer latches base_addr one edge later.
      if (w_sel_fire) begin
        if (w_found) begin
          r_latest_idx   <= r_wr_idx;
          r_latest_valid <= 1'b1;
          r_frame_cnt    <= r_frame_cnt + C_CNT_BITS'(1);
          r_wr_idx       <= w_next_idx;
          r_base_addr    <= w_next_addr;
        end else begin
          r_drop_cnt     <= r_drop_cnt + C_CNT_BITS'(1);
        end
      end
    end
  end

  assign wr_if.soft_resetn = r_soft_resetn;
  assign wr_if.base_addr   = r_base_addr;
  assign wr_idx            = r_wr_idx;
  assign latest_idx        = r_latest_idx;
  assign latest_valid      = r_latest_valid;
  assign frame_cnt         = r_frame_cnt;
  assign drop_cnt          = r_drop_cnt;
  assign busy              = r_busy;

endmodule

// File: doc/s2mm_frame_scheduler.md
Name: s2mm_frame_scheduler

Overview:
- Sequences the S2MM stream-to-memory frame writer across a ring of 2..4 frame buffers in DDR, as double/triple buffering.
- Drives the writer's soft_resetn and base_addr; consumes its frame_pulse and resetting.
- Publishes the most recently completed buffer to a downstream reader, and never selects the buffer the reader has locked.
- Owns start/stop of capture so a stop request never leaves a half-issued AXI burst.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, width of buffer and base addresses
C_BUF_NUM, 3, number of frame buffers, legal 2..4
C_IDX_BITS, 2, width of buffer index fields (fixed 2, covers 4 buffers)
C_CNT_BITS, 16, width of frame/drop counters (wrap modulo 2^C_CNT_BITS)
C_STOP_MIN, 2, minimum cycles spent in STOP before resetting is trusted

Ports:
M_AXI_ACLK  in  1  block clock, same as the writer's AXI clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
enable  in  1  capture request from register bank, level
buf_addr  in  C_BUF_NUM*C_M_AXI_ADDR_WIDTH  packed buffer base addresses, buffer i at slice i
rd_lock  in  1  reader holds buffer rd_idx
rd_idx  in  C_IDX_BITS  buffer held by reader
frame_pulse  in  1  writer: one-cycle pulse, frame fully written (last BRESP taken)
resetting  in  1  writer: soft reset in progress
soft_resetn  out  1  to writer, active-low soft reset
base_addr  out  C_M_AXI_ADDR_WIDTH  to writer, start address of next frame
wr_idx  out  C_IDX_BITS  buffer currently being written
latest_idx  out  C_IDX_BITS  newest complete buffer
latest_valid  out  1  latest_idx holds a complete frame
frame_cnt  out  C_CNT_BITS  published frames
drop_cnt  out  C_CNT_BITS  frames overwritten without publish
busy  out  1  state != IDLE

Behaviour:
- Reset values (async assert, sync deassert handled upstream): state=IDLE, soft_resetn=0, base_addr=0, wr_idx=0, latest_idx=0, latest_valid=0, frame_cnt=0, drop_cnt=0, busy=0, stop counter=0.
- All outputs are registered.
- FSM states: IDLE, RUN, STOP.
- IDLE:
  - soft_resetn=0.
  - base_addr <= buf_addr[wr_idx] every cycle.
  - Go to RUN when enable=1 && resetting=0.
  - On the transition: soft_resetn <= 1 and base_addr <= buf_addr[wr_idx] in the same edge.
- RUN:
  - soft_resetn=1.
  - On frame_pulse, run the selection step (below).
  - enable=0 → STOP; soft_resetn <= 0 on the same edge; stop counter loaded with C_STOP_MIN.
  - frame_pulse and enable falling in the same cycle: selection is performed AND the FSM moves to STOP.
- STOP:
  - soft_resetn=0; the stop counter decrements to 0.
  - Go to IDLE when counter==0 && resetting==0.
  - A frame_pulse arriving in STOP is still processed by the selection step, because the frame is complete in memory.
  - enable re-asserted during STOP is ignored until IDLE is reached.
- Selection step (registered, 1-cycle latency):
  - Executes on the edge sampling frame_pulse=1. wr_idx and base_addr are valid the following cycle.
  - Required because the writer latches base_addr two edges after its frame_pulse.
  - Candidates, in order: (wr_idx+1), (wr_idx+2), … mod C_BUF_NUM.
  - Exclude the current wr_idx, and exclude rd_idx when rd_lock=1 (rd_lock/rd_idx sampled on the frame_pulse edge).
  - Candidate found: latest_idx <= wr_idx, latest_valid <= 1, frame_cnt++, wr_idx <= candidate, base_addr <= buf_addr[candidate].
  - No candidate (only possible with C_BUF_NUM=2 and reader holding the other buffer): wr_idx unchanged, latest unchanged, drop_cnt++.
- rd_idx >= C_BUF_NUM is treated as no lock.
- Counters wrap silently.
- Aborted frames produce no frame_pulse and are not counted. The next RUN rewrites the same wr_idx from offset 0.
- buf_addr changes are only guaranteed to take effect at the next selection step or while in IDLE.
- Async reset mid-frame: soft_resetn drops to 0 immediately. The writer is on the same reset, so no handshake is required.

Decomposition:
- Package s2mm_sched_pkg:
  - state encoding localparams ST_IDLE/ST_RUN/ST_STOP;
  - clogb2 function;
  - C_IDX_BITS constant.
- Sub-module s2mm_next_buf_sel: purely combinational candidate search.
  - Inputs: wr_idx, rd_lock, rd_idx.
  - Outputs: found, next_idx.
  - Parameterised by C_BUF_NUM; unit-testable exhaustively.

Test Plan:
1. Reset, enable=1, resetting=0 → soft_resetn=1 at cycle 2, base_addr=buf_addr[0], busy=1, latest_valid=0.
2. C_BUF_NUM=3, rd_lock=0, three frame_pulses → wr_idx sequence 1,2,0; latest_idx 0,1,2; frame_cnt=3; base_addr updated 1 cycle after each pulse.
3. C_BUF_NUM=3, wr_idx=0, rd_lock=1, rd_idx=1, frame_pulse → wr_idx=2, latest_idx=0; frame_cnt increments.
4. C_BUF_NUM=2, wr_idx=0, rd_lock=1, rd_idx=1, frame_pulse → wr_idx=0, latest_valid unchanged, drop_cnt=1, frame_cnt unchanged.
5. RUN, enable=0 with resetting held 1 for 6 cycles → soft_resetn=0 next edge; state STOP ≥ C_STOP_MIN cycles; IDLE one edge after resetting falls; wr_idx unchanged.
6. frame_pulse and enable=0 in same cycle → latest_idx updated, frame_cnt++, state STOP. Separately, async reset asserted mid-RUN → all outputs at reset values without a clock edge.
